// File: rtl/mem_wb_pipe_reg_if.sv
// MEM/WB bundle: M-stage inputs, stall/flush controls and W-stage outputs.
// master drives the M side and observes W; slave is the pipeline register.
interface mem_wb_pipe_reg_if #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 64
);
  logic             ValidM;
  logic             RegWriteM;
  logic [1:0]       ResultSrcM;
  logic [2:0]       Funct3M;
  logic [XLEN-1:0]  ALUResultM;
  logic [RA_W-1:0]  RdM;
  logic [XLEN-1:0]  PCPlus4M;
  logic [XLEN-1:0]  RD;
  logic             StallW;
  logic             FlushW;
  logic             ValidW;
  logic             RegWriteW;
  logic [1:0]       ResultSrcW;
  logic [XLEN-1:0]  ALUResultW;
  logic [XLEN-1:0]  ReadDataW;
  logic [RA_W-1:0]  RdW;
  logic [XLEN-1:0]  PCPlus4W;
  logic [XLEN-1:0]  ResultW;
  logic [CNT_W-1:0] InstRet;

  modport master (
    output ValidM, RegWriteM, ResultSrcM, Funct3M,
    output ALUResultM, RdM, PCPlus4M, RD,
    output StallW, FlushW,
    input  ValidW, RegWriteW, ResultSrcW, ALUResultW,
    input  ReadDataW, RdW, PCPlus4W, ResultW, InstRet
  );

  modport slave (
    input  ValidM, RegWriteM, ResultSrcM, Funct3M,
    input  ALUResultM, RdM, PCPlus4M, RD,
    input  StallW, FlushW,
    output ValidW, RegWriteW, ResultSrcW, ALUResultW,
    output ReadDataW, RdW, PCPlus4W, ResultW, InstRet
  );
endinterface

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register: load extraction, x0 write suppression,
// writeback mux and retired-instruction counter.
// Ports: CLK, RST (async, active-high), bus (slave side of the bundle).
// XLEN must be 32 or 64.
module mem_wb_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 64
) (
  input logic CLK,
  input logic RST,
  mem_wb_pipe_reg_if.slave bus
);

  localparam int OW = (XLEN == 64) ? 3 : 2;

  logic [OW-1:0]    ofs;
  logic             wSel;
  logic [XLEN-1:0]  shB;
  logic [XLEN-1:0]  shH;
  logic [XLEN-1:0]  shW;
  logic [XLEN-1:0]  ldData;
  logic             regWrM;

  logic             validQ;
  logic             regWrQ;
  logic [1:0]       srcQ;
  logic [XLEN-1:0]  aluQ;
  logic [XLEN-1:0]  rdDataQ;
  logic [RA_W-1:0]  rdQ;
  logic [XLEN-1:0]  pc4Q;
  logic [CNT_W-1:0] cntQ;
  logic [XLEN-1:0]  result;

  // Lanes are little-endian; shift the wanted lane down to bit 0.
  // Halfword ignores ofs[0]; word lane only exists on XLEN=64.
  always_comb begin
    ofs    = bus.ALUResultM[OW-1:0];
    wSel   = (XLEN == 64) ? ofs[OW-1] : 1'b0;
    shB    = bus.RD >> {ofs, 3'b000};
    shH    = bus.RD >> {ofs[OW-1:1], 4'b0000};
    shW    = bus.RD >> {wSel, 5'b00000};
    ldData = bus.RD;
    case (bus.Funct3M)
      3'b000: ldData = XLEN'($signed(shB[7:0]));
      3'b100: ldData = XLEN'(shB[7:0]);
      3'b001: ldData = XLEN'($signed(shH[15:0]));
      3'b101: ldData = XLEN'(shH[15:0]);
      3'b010: ldData = XLEN'($signed(shW[31:0]));
      3'b110: begin
        if (XLEN == 64) ldData = XLEN'(shW[31:0]);
      end
      default: ldData = bus.RD;
    endcase
  end

  assign regWrM = bus.RegWriteM & bus.ValidM & (bus.RdM != '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      validQ  <= 1'b0;
      regWrQ  <= 1'b0;
      srcQ    <= '0;
      aluQ    <= '0;
      rdDataQ <= '0;
      rdQ     <= '0;
      pc4Q    <= '0;
      cntQ    <= '0;
    end else if (bus.FlushW) begin
      validQ  <= 1'b0;
      regWrQ  <= 1'b0;
      srcQ    <= '0;
      aluQ    <= '0;
      rdDataQ <= '0;
      rdQ     <= '0;
      pc4Q    <= '0;
    end else if (!bus.StallW) begin
      validQ  <= bus.ValidM;
      regWrQ  <= regWrM;
      srcQ    <= bus.ResultSrcM;
      aluQ    <= bus.ALUResultM;
      rdDataQ <= ldData;
      rdQ     <= bus.RdM;
      pc4Q    <= bus.PCPlus4M;
      if (bus.ValidM) cntQ <= cntQ + CNT_W'(1);
    end
  end

  always_comb begin
    result = '0;
    case (srcQ)
      2'b00:   result = aluQ;
      2'b01:   result = rdDataQ;
      2'b10:   result = pc4Q;
      default: result = '0;
    endcase
  end

  assign bus.ValidW     = validQ;
  assign bus.RegWriteW  = regWrQ;
  assign bus.ResultSrcW = srcQ;
  assign bus.ALUResultW = aluQ;
  assign bus.ReadDataW  = rdDataQ;
  assign bus.RdW        = rdQ;
  assign bus.PCPlus4W   = pc4Q;
  assign bus.ResultW    = result;
  assign bus.InstRet    = cntQ;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Bench for mem_wb_pipe_reg: XLEN=32, XLEN=64 and CNT_W=4 instances.
// Directed load vectors plus stall/flush/reset/wrap sequences.
module tb_mem_wb_pipe_reg;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  mem_wb_pipe_reg_if #(.XLEN(32), .RA_W(5), .CNT_W(64)) if32 ();
  mem_wb_pipe_reg_if #(.XLEN(64), .RA_W(5), .CNT_W(64)) if64 ();
  mem_wb_pipe_reg_if #(.XLEN(32), .RA_W(5), .CNT_W(4))  ifc ();

  mem_wb_pipe_reg #(.XLEN(32), .RA_W(5), .CNT_W(64)) u32 (
    .CLK(CLK), .RST(RST), .bus(if32.slave)
  );
  mem_wb_pipe_reg #(.XLEN(64), .RA_W(5), .CNT_W(64)) u64 (
    .CLK(CLK), .RST(RST), .bus(if64.slave)
  );
  mem_wb_pipe_reg #(.XLEN(32), .RA_W(5), .CNT_W(4)) uc (
    .CLK(CLK), .RST(RST), .bus(ifc.slave)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  src;
    logic [63:0] alu;
    logic [63:0] expRd;
    logic [63:0] expRes;
  } vec_t;

  vec_t v32[11];
  vec_t v64[9];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int expCnt;

    if32.ValidM = 0; if32.RegWriteM = 0; if32.ResultSrcM = 0;
    if32.Funct3M = 0; if32.ALUResultM = 0; if32.RdM = 0;
    if32.PCPlus4M = 0; if32.RD = 0; if32.StallW = 0; if32.FlushW = 0;
    if64.ValidM = 0; if64.RegWriteM = 0; if64.ResultSrcM = 0;
    if64.Funct3M = 0; if64.ALUResultM = 0; if64.RdM = 0;
    if64.PCPlus4M = 0; if64.RD = 0; if64.StallW = 0; if64.FlushW = 0;
    ifc.ValidM = 0; ifc.RegWriteM = 0; ifc.ResultSrcM = 0;
    ifc.Funct3M = 0; ifc.ALUResultM = 0; ifc.RdM = 0;
    ifc.PCPlus4M = 0; ifc.RD = 0; ifc.StallW = 0; ifc.FlushW = 0;

    v32[0]  = '{3'b000, 2'b01, 64'h1001, 64'h00000012, 64'h00000012};
    v32[1]  = '{3'b000, 2'b01, 64'h1003, 64'hFFFFFF80, 64'hFFFFFF80};
    v32[2]  = '{3'b100, 2'b01, 64'h1002, 64'h000000FF, 64'h000000FF};
    v32[3]  = '{3'b101, 2'b01, 64'h1002, 64'h000080FF, 64'h000080FF};
    v32[4]  = '{3'b001, 2'b01, 64'h1003, 64'hFFFF80FF, 64'hFFFF80FF};
    v32[5]  = '{3'b001, 2'b01, 64'h1000, 64'h00001234, 64'h00001234};
    v32[6]  = '{3'b010, 2'b01, 64'h1000, 64'h80FF1234, 64'h80FF1234};
    v32[7]  = '{3'b010, 2'b00, 64'h1000, 64'h80FF1234, 64'h00001000};
    v32[8]  = '{3'b011, 2'b10, 64'h1000, 64'h80FF1234, 64'h00002004};
    v32[9]  = '{3'b111, 2'b11, 64'h1001, 64'h80FF1234, 64'h00000000};
    v32[10] = '{3'b110, 2'b01, 64'h1000, 64'h80FF1234, 64'h80FF1234};

    v64[0] = '{3'b010, 2'b01, 64'h1004,
               64'hFFFFFFFFFEDCBA98, 64'hFFFFFFFFFEDCBA98};
    v64[1] = '{3'b110, 2'b01, 64'h1004,
               64'h00000000FEDCBA98, 64'h00000000FEDCBA98};
    v64[2] = '{3'b011, 2'b01, 64'h1000,
               64'hFEDCBA9876543210, 64'hFEDCBA9876543210};
    v64[3] = '{3'b100, 2'b01, 64'h1007,
               64'h00000000000000FE, 64'h00000000000000FE};
    v64[4] = '{3'b001, 2'b01, 64'h1006,
               64'hFFFFFFFFFFFFFEDC, 64'hFFFFFFFFFFFFFEDC};
    v64[5] = '{3'b010, 2'b01, 64'h1000,
               64'h0000000076543210, 64'h0000000076543210};
    v64[6] = '{3'b000, 2'b01, 64'h1004,
               64'hFFFFFFFFFFFFFF98, 64'hFFFFFFFFFFFFFF98};
    v64[7] = '{3'b001, 2'b01, 64'h1007,
               64'hFFFFFFFFFFFFFEDC, 64'hFFFFFFFFFFFFFEDC};
    v64[8] = '{3'b101, 2'b10, 64'h1002,
               64'h0000000000007654, 64'h0000000000002004};

    // reset state
    step();
    step();
    chk("rst_valid", 64'(if32.ValidW), 64'd0);
    chk("rst_result", 64'(if32.ResultW), 64'd0);
    chk("rst_instret", if32.InstRet, 64'd0);
    chk("rst_instret64", if64.InstRet, 64'd0);
    RST = 1'b0;

    // XLEN=32 load table
    if32.RD = 32'h80FF1234;
    if32.PCPlus4M = 32'h2004;
    if32.ValidM = 1;
    if32.RegWriteM = 1;
    if32.RdM = 5'd3;
    for (int i = 0; i < 11; i++) begin
      if32.Funct3M = v32[i].f3;
      if32.ResultSrcM = v32[i].src;
      if32.ALUResultM = v32[i].alu[31:0];
      step();
      chk($sformatf("v32[%0d].rdata", i), 64'(if32.ReadDataW),
          v32[i].expRd);
      chk($sformatf("v32[%0d].result", i), 64'(if32.ResultW),
          v32[i].expRes);
      chk($sformatf("v32[%0d].regw", i), 64'(if32.RegWriteW), 64'd1);
    end
    expCnt = 11;
    chk("v32_instret", if32.InstRet, 64'(expCnt));

    // XLEN=64 load table
    if32.ValidM = 0;
    if64.RD = 64'hFEDCBA9876543210;
    if64.PCPlus4M = 64'h2004;
    if64.ValidM = 1;
    for (int i = 0; i < 9; i++) begin
      if64.Funct3M = v64[i].f3;
      if64.ResultSrcM = v64[i].src;
      if64.ALUResultM = v64[i].alu;
      step();
      chk($sformatf("v64[%0d].rdata", i), if64.ReadDataW, v64[i].expRd);
      chk($sformatf("v64[%0d].result", i), if64.ResultW, v64[i].expRes);
    end
    chk("v64_instret", if64.InstRet, 64'd9);
    if64.ValidM = 0;

    // x0 write suppression
    if32.ValidM = 1; if32.RegWriteM = 1; if32.RdM = 5'd0;
    step();
    expCnt++;
    chk("x0_regw", 64'(if32.RegWriteW), 64'd0);
    chk("x0_valid", 64'(if32.ValidW), 64'd1);
    chk("x0_instret", if32.InstRet, 64'(expCnt));
    if32.ValidM = 0; if32.RdM = 5'd5;
    step();
    chk("inv_regw", 64'(if32.RegWriteW), 64'd0);
    chk("inv_valid", 64'(if32.ValidW), 64'd0);
    chk("inv_instret", if32.InstRet, 64'(expCnt));
    if32.ValidM = 1;
    step();
    expCnt++;
    chk("rd5_regw", 64'(if32.RegWriteW), 64'd1);
    chk("rd5_rdw", 64'(if32.RdW), 64'd5);

    // stall holds, flush clears
    if32.ResultSrcM = 2'b00;
    if32.ALUResultM = 32'h10;
    step();
    expCnt++;
    chk("pre_stall_alu", 64'(if32.ALUResultW), 64'h10);
    if32.StallW = 1;
    for (int i = 0; i < 2; i++) begin
      if32.ALUResultM = 32'h100 + 32'(i);
      if32.RdM = 5'(7 + i);
      step();
      chk($sformatf("stall%0d_alu", i), 64'(if32.ALUResultW), 64'h10);
      chk($sformatf("stall%0d_instret", i), if32.InstRet, 64'(expCnt));
    end
    if32.FlushW = 1;
    step();
    chk("flush_valid", 64'(if32.ValidW), 64'd0);
    chk("flush_regw", 64'(if32.RegWriteW), 64'd0);
    chk("flush_alu", 64'(if32.ALUResultW), 64'd0);
    chk("flush_instret", if32.InstRet, 64'(expCnt));
    if32.StallW = 0; if32.FlushW = 0;
    if32.ALUResultM = 32'h20;
    step();
    expCnt++;
    chk("resume_alu", 64'(if32.ALUResultW), 64'h20);
    chk("resume_instret", if32.InstRet, 64'(expCnt));

    // asynchronous reset mid-cycle, with stall active
    if32.StallW = 1;
    #2;
    RST = 1'b1;
    #1;
    chk("arst_alu", 64'(if32.ALUResultW), 64'd0);
    chk("arst_valid", 64'(if32.ValidW), 64'd0);
    chk("arst_result", 64'(if32.ResultW), 64'd0);
    chk("arst_instret", if32.InstRet, 64'd0);
    chk("arst_instret64", if64.InstRet, 64'd0);
    step();
    RST = 1'b0;
    if32.StallW = 0;
    if32.ALUResultM = 32'h30;
    step();
    chk("post_rst_alu", 64'(if32.ALUResultW), 64'h30);
    chk("post_rst_instret", if32.InstRet, 64'd1);
    if32.ValidM = 0;

    // 4-bit counter wrap
    ifc.ValidM = 1;
    for (int i = 0; i < 15; i++) step();
    chk("wrap_15", 64'(ifc.InstRet), 64'd15);
    step();
    chk("wrap_0", 64'(ifc.InstRet), 64'd0);
    step();
    chk("wrap_1", 64'(ifc.InstRet), 64'd1);
    ifc.ValidM = 0;
    step();
    chk("wrap_hold", 64'(ifc.InstRet), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe_reg.md
MEM_WB_PIPE_REG -- requirements
Module: mem_wb_pipe_reg

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 or 64 only.
REQ-002 SHALL have parameter RA_W, default 5, register-address width.
REQ-003 SHALL have parameter CNT_W, default 64, retired-instruction counter width.
REQ-004 SHALL have ports: CLK in 1 clock; RST in 1 reset. One clock; reset is asynchronous and active-high.
REQ-005 SHALL have ports: ValidM in 1 M-stage slot holds a real instruction; RegWriteM in 1; ResultSrcM in 2; Funct3M in 3 load-size code; ALUResultM in XLEN, result or load address; RdM in RA_W; PCPlus4M in XLEN; RD in XLEN, raw aligned memory word.
REQ-006 SHALL have ports: StallW in 1 hold W register; FlushW in 1 insert bubble.
REQ-007 SHALL have ports: ValidW out 1; RegWriteW out 1; ResultSrcW out 2; ALUResultW out XLEN; ReadDataW out XLEN, extracted/extended load data; RdW out RA_W; PCPlus4W out XLEN; ResultW out XLEN, selected writeback value; InstRet out CNT_W.

Function
REQ-008 SHALL update all W registers only on posedge CLK; priority RST > FlushW > StallW > capture.
REQ-009 Capture: load ValidM, ResultSrcM, ALUResultM, RdM, PCPlus4M, extracted load data; one-cycle latency M to W.
REQ-010 Captured RegWrite SHALL be RegWriteM & ValidM & (RdM != 0); x0 writes never reach W.
REQ-011 StallW=1 (FlushW=0): every W register, including InstRet, holds its value.
REQ-012 FlushW=1: ValidW=0, RegWriteW=0, all other W data registers cleared to 0, regardless of StallW.
REQ-013 Load extraction on capture, byte offset ofs = ALUResultM[1:0] (XLEN=32) or ALUResultM[2:0] (XLEN=64), lanes little-endian.
REQ-014 Funct3M 000 LB: byte at ofs, sign-extended; 100 LBU: zero-extended.
REQ-015 Funct3M 001 LH / 101 LHU: halfword at ofs with ofs[0] ignored, sign / zero-extended; misalignment not trapped.
REQ-016 Funct3M 010 LW: word at ofs[2] (XLEN=64) or whole word (XLEN=32), sign-extended; 110 LWU (XLEN=64 only): zero-extended.
REQ-017 Funct3M 011 LD (XLEN=64): full word; any other code, or 011/110 with XLEN=32: full RD unmodified.
REQ-018 ResultW combinational from W registers: ResultSrcW 00 ALUResultW, 01 ReadDataW, 10 PCPlus4W, 11 zero.
REQ-019 InstRet SHALL increment by 1 on each capture edge with ValidM=1; no increment on stall, flush, or ValidM=0.
REQ-020 InstRet SHALL wrap from 2^CNT_W-1 to 0 without flag.

Reset
REQ-021 RST=1 SHALL immediately, independent of CLK, clear every W register and InstRet to 0; ResultW therefore 0.
REQ-022 RST deassertion mid-stream: first capture on the first posedge with RST=0; no partial state retained.
REQ-023 RST asserted during StallW or FlushW SHALL still clear all state.

Verification
REQ-024 Reset: drive RST=1 mid-cycle with nonzero W contents -> all outputs 0 before next edge, InstRet=0.
REQ-025 Loads XLEN=32, RD=0x80FF1234: LB ofs=1 -> 0x00000012; LB ofs=3 -> 0xFFFFFF80; LHU ofs=2 -> 0x000080FF; LH ofs=3 -> 0xFFFF80FF; LW -> 0x80FF1234; ResultSrcM=01 -> ResultW equals ReadDataW.
REQ-026 Stall/flush: capture ALUResultM=0x10, then StallW=1 2 cycles with changing inputs -> ALUResultW stays 0x10, InstRet unchanged; StallW=1 and FlushW=1 together -> ValidW=0, RegWriteW=0, InstRet unchanged.
REQ-027 x0 suppression: RegWriteM=1, ValidM=1, RdM=0 -> RegWriteW=0, ValidW=1, InstRet +1; RegWriteM=1, ValidM=0, RdM=5 -> RegWriteW=0, InstRet unchanged.
REQ-028 Counter wrap: CNT_W=4, 16 valid captures from reset -> InstRet returns to 0, next valid capture -> 1.
REQ-029 XLEN=64, RD=0xFEDCBA9876543210: LW ofs=4 -> 0xFFFFFFFFFEDCBA98; LWU ofs=4 -> 0x00000000FEDCBA98; LD -> RD unchanged; LBU ofs=7 -> 0xFE.
